// File: rtl/eth_mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO PHY responder.
package eth_mdio_pkg;

  typedef enum logic [2:0] {
    PREAMBLE,
    START,
    OP,
    PHYAD,
    REGAD,
    TA,
    DATA
  } mdio_state_e;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam int REG_BMCR   = 0;
  localparam int REG_BMSR   = 1;
  localparam int REG_PHYID1 = 2;
  localparam int REG_PHYID2 = 3;

  localparam int PREAMBLE_LEN = 32;

  // Status and identifier registers ignore writes.
  function automatic logic is_read_only(input logic [4:0] regad);
    return (regad == 5'(REG_BMSR)) || (regad == 5'(REG_PHYID1)) ||
           (regad == 5'(REG_PHYID2));
  endfunction

endpackage

// File: rtl/mdio_phy_responder_if.sv
// MDIO bus seen by the PHY: management clock, resolved data line and the
// responder's drive value/enable.
interface mdio_phy_responder_if;
  logic phy_mdc;
  logic phy_mdio_i;
  logic phy_mdio_o;
  logic phy_mdio_oe;

  modport master (
    output phy_mdc,
    output phy_mdio_i,
    input  phy_mdio_o,
    input  phy_mdio_oe
  );

  modport slave (
    input  phy_mdc,
    input  phy_mdio_i,
    output phy_mdio_o,
    output phy_mdio_oe
  );
endinterface

// File: rtl/mdio_sync_edge.sv
// Brings MDC/MDIO into the clk_int domain and flags each MDC rising edge.
// mdc_rise is a registered one-cycle strobe three clk_int cycles after the
// pin edge; mdio_s is delayed to line up with it.
module mdio_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic mdc,
  input  logic mdio,
  output logic mdc_rise,
  output logic mdio_s
);

  logic mdc_meta_q, mdc_sync_q, mdc_prev_q, mdc_rise_q;
  logic mdio_meta_q, mdio_sync_q, mdio_s_q;
  logic mdc_rise_d;

  // Rising edge seen on the synchronised clock.
  always_comb begin
    mdc_rise_d = mdc_sync_q & ~mdc_prev_q;
  end

  // Two-flop synchronisers plus edge/data alignment stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_meta_q  <= 1'b0;
      mdc_sync_q  <= 1'b0;
      mdc_prev_q  <= 1'b0;
      mdc_rise_q  <= 1'b0;
      mdio_meta_q <= 1'b0;
      mdio_sync_q <= 1'b0;
      mdio_s_q    <= 1'b0;
    end else begin
      mdc_meta_q  <= mdc;
      mdc_sync_q  <= mdc_meta_q;
      mdc_prev_q  <= mdc_sync_q;
      mdc_rise_q  <= mdc_rise_d;
      mdio_meta_q <= mdio;
      mdio_sync_q <= mdio_meta_q;
      mdio_s_q    <= mdio_sync_q;
    end
  end

  assign mdc_rise = mdc_rise_q;
  assign mdio_s   = mdio_s_q;

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY responder with a small 16-bit register file.
// Build option: MDIO_PREAMBLE_SUPPRESS_EN lets a single idle 1 stand in for
// the 32-bit preamble so frames can run back to back.
module mdio_phy_responder
  import eth_mdio_pkg::*;
#(
  parameter int          NUM_REGS     = 32,
  parameter logic [31:0] PHY_ID       = 32'h0141_0DD0,
  parameter logic [15:0] BMCR_DEFAULT = 16'h1140,
  parameter logic [15:0] BMSR_BASE    = 16'h7949
) (
  input  logic                 clk_int,
  input  logic                 rst_int_n,
  mdio_phy_responder_if.slave  mdio,
  input  logic [4:0]           phy_addr,
  input  logic                 link_up,
  output logic                 wr_valid,
  output logic [4:0]           wr_addr,
  output logic [15:0]          wr_data,
  output logic                 phy_reset_req
);

  logic        mdc_rise, bit_in;
  mdio_state_e state_q;
  logic [5:0]  cnt_q;
  logic [15:0] shift_q, rdata_q;
  logic [4:0]  regad_q;
  logic        is_rd_q, match_q;
  logic        oe_q, o_q, wr_valid_q, reset_req_q;
  logic [4:0]  wr_addr_q;
  logic [15:0] wr_data_q;
  logic [15:0] regs_q [NUM_REGS];

  logic [4:0]  regad_in;
  logic [15:0] wdata_in, rd_now;
  logic        pre_ok;

  mdio_sync_edge u_sync (
    .clk      (clk_int),
    .rst_n    (rst_int_n),
    .mdc      (mdio.phy_mdc),
    .mdio     (mdio.phy_mdio_i),
    .mdc_rise (mdc_rise),
    .mdio_s   (bit_in)
  );

  // Field values completed by the current bit, plus the read snapshot source.
  always_comb begin
    regad_in = {shift_q[3:0], bit_in};
    wdata_in = {shift_q[14:0], bit_in};
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    pre_ok = (cnt_q != 6'd0);
`else
    pre_ok = (cnt_q == 6'(PREAMBLE_LEN));
`endif
    rd_now = 16'h0000;
    if (int'(regad_in) < NUM_REGS) begin
      case (regad_in)
        5'(REG_BMSR):   rd_now = {BMSR_BASE[15:3], link_up, BMSR_BASE[1:0]};
        5'(REG_PHYID1): rd_now = PHY_ID[31:16];
        5'(REG_PHYID2): rd_now = PHY_ID[15:0];
        default:        rd_now = regs_q[regad_in];
      endcase
    end
  end

  // Frame decoder, register file and registered bus/notification outputs.
  always_ff @(posedge clk_int or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= PREAMBLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rdata_q     <= '0;
      regad_q     <= '0;
      is_rd_q     <= 1'b0;
      match_q     <= 1'b0;
      oe_q        <= 1'b0;
      o_q         <= 1'b0;
      wr_valid_q  <= 1'b0;
      reset_req_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= (i == REG_BMCR) ? BMCR_DEFAULT : 16'h0000;
    end else begin
      wr_valid_q  <= 1'b0;
      reset_req_q <= 1'b0;
      if (mdc_rise) begin
        case (state_q)
          PREAMBLE: begin
            if (bit_in) begin
              if (cnt_q < 6'(PREAMBLE_LEN)) cnt_q <= cnt_q + 6'd1;
            end else begin
              cnt_q <= '0;
              if (pre_ok) state_q <= START;
            end
          end
          START: begin
            cnt_q   <= '0;
            state_q <= bit_in ? OP : PREAMBLE;
          end
          OP: begin
            shift_q <= wdata_in;
            if (cnt_q == 6'd0) begin
              cnt_q <= 6'd1;
            end else begin
              cnt_q <= '0;
              case ({shift_q[0], bit_in})
                OP_READ:  begin is_rd_q <= 1'b1; state_q <= PHYAD; end
                OP_WRITE: begin is_rd_q <= 1'b0; state_q <= PHYAD; end
                default:  state_q <= PREAMBLE;
              endcase
            end
          end
          PHYAD: begin
            shift_q <= wdata_in;
            if (cnt_q == 6'd4) begin
              match_q <= (regad_in == phy_addr);
              cnt_q   <= '0;
              state_q <= REGAD;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          REGAD: begin
            shift_q <= wdata_in;
            if (cnt_q == 6'd4) begin
              regad_q <= regad_in;
              rdata_q <= rd_now;
              cnt_q   <= '0;
              state_q <= TA;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          TA: begin
            if (cnt_q == 6'd0) begin
              if (is_rd_q && match_q) begin
                oe_q <= 1'b1;
                o_q  <= 1'b0;
              end
              cnt_q <= 6'd1;
            end else begin
              if (is_rd_q && match_q) begin
                o_q     <= rdata_q[15];
                rdata_q <= {rdata_q[14:0], 1'b0};
              end
              cnt_q   <= '0;
              state_q <= DATA;
            end
          end
          DATA: begin
            shift_q <= wdata_in;
            if (cnt_q == 6'd15) begin
              oe_q    <= 1'b0;
              o_q     <= 1'b0;
              cnt_q   <= '0;
              state_q <= PREAMBLE;
              if (!is_rd_q && match_q && (int'(regad_q) < NUM_REGS)) begin
                wr_valid_q <= 1'b1;
                wr_addr_q  <= regad_q;
                wr_data_q  <= wdata_in;
                if (regad_q == 5'(REG_BMCR)) begin
                  if (wdata_in[15]) begin
                    reset_req_q <= 1'b1;
                    for (int i = 0; i < NUM_REGS; i++)
                      regs_q[i] <= (i == REG_BMCR) ? BMCR_DEFAULT : 16'h0000;
                  end else begin
                    regs_q[REG_BMCR] <= {1'b0, wdata_in[14:0]};
                  end
                end else if (!is_read_only(regad_q)) begin
                  regs_q[regad_q] <= wdata_in;
                end
              end
            end else begin
              cnt_q <= cnt_q + 6'd1;
              if (is_rd_q && match_q) begin
                o_q     <= rdata_q[15];
                rdata_q <= {rdata_q[14:0], 1'b0};
              end
            end
          end
          default: begin
            state_q <= PREAMBLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign mdio.phy_mdio_o  = o_q;
  assign mdio.phy_mdio_oe = oe_q;
  assign wr_valid         = wr_valid_q;
  assign wr_addr          = wr_addr_q;
  assign wr_data          = wr_data_q;
  assign phy_reset_req    = reset_req_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Self-checking bench for mdio_phy_responder: acts as the MDIO master and
// compares against a register-level model of the PHY.
module tb_mdio_phy_responder;

  logic        clk = 1'b0;
  logic        rst_int_n = 1'b0;
  logic [4:0]  phy_addr = 5'd1;
  logic        link_up = 1'b0;
  logic        wr_valid, phy_reset_req;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        m_drive = 1'b1;

  int tests_run = 0;
  int failed = 0;
  int wr_cnt = 0;
  int rr_cnt = 0;
  int oe_cnt = 0;

  logic [15:0] m_regs [32];

  mdio_phy_responder_if mif ();

  // Open-drain style bus: the PHY wins while it drives, otherwise the master.
  assign mif.phy_mdio_i = mif.phy_mdio_oe ? mif.phy_mdio_o : m_drive;

  mdio_phy_responder dut (
    .clk_int       (clk),
    .rst_int_n     (rst_int_n),
    .mdio          (mif.slave),
    .phy_addr      (phy_addr),
    .link_up       (link_up),
    .wr_valid      (wr_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .phy_reset_req (phy_reset_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_valid) wr_cnt <= wr_cnt + 1;
    if (phy_reset_req) rr_cnt <= rr_cnt + 1;
    if (mif.phy_mdio_oe) oe_cnt <= oe_cnt + 1;
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
    m_regs[0] = 16'h1140;
  endtask

  function automatic logic [15:0] model_read(input logic [4:0] a);
    case (a)
      5'd1:    return link_up ? 16'h794D : 16'h7949;
      5'd2:    return 16'h0141;
      5'd3:    return 16'h0DD0;
      default: return m_regs[a];
    endcase
  endfunction

  // Returns 1 when the write asks for a soft reset.
  task automatic model_write(input logic [4:0] a, input logic [15:0] d, output bit rst_req);
    rst_req = 1'b0;
    if (a == 5'd0) begin
      if (d[15]) begin
        model_reset();
        rst_req = 1'b1;
      end else begin
        m_regs[0] = d & 16'h7FFF;
      end
    end else if (a > 5'd3) begin
      m_regs[a] = d;
    end
  endtask

  // ---------------- MDIO master ----------------
  task automatic bit_cyc(input logic b, output logic s, output logic oe);
    m_drive = b;
    repeat (6) @(negedge clk);
    s  = mif.phy_mdio_i;
    oe = mif.phy_mdio_oe;
    mif.phy_mdc = 1'b1;
    repeat (6) @(negedge clk);
    mif.phy_mdc = 1'b0;
  endtask

  task automatic frame(input int pre, input bit rd, input logic [4:0] pa,
                       input logic [4:0] ra, input logic [15:0] wd, input int nd,
                       output logic [15:0] rv, output logic ta1_oe,
                       output logic ta2_oe, output logic ta2_v);
    logic s, oe;
    rv = 16'h0000;
    for (int i = 0; i < pre; i++) bit_cyc(1'b1, s, oe);
    bit_cyc(1'b0, s, oe);
    bit_cyc(1'b1, s, oe);
    bit_cyc(rd ? 1'b1 : 1'b0, s, oe);
    bit_cyc(rd ? 1'b0 : 1'b1, s, oe);
    for (int i = 4; i >= 0; i--) bit_cyc(pa[i], s, oe);
    for (int i = 4; i >= 0; i--) bit_cyc(ra[i], s, oe);
    bit_cyc(1'b1, s, oe);
    ta1_oe = oe;
    bit_cyc(rd ? 1'b1 : 1'b0, s, oe);
    ta2_oe = oe;
    ta2_v  = s;
    for (int i = 0; i < nd; i++) begin
      bit_cyc(rd ? 1'b1 : wd[15 - i], s, oe);
      rv = {rv[14:0], s};
    end
    m_drive = 1'b1;
  endtask

  task automatic do_read(input logic [4:0] pa, input logic [4:0] ra, output logic [15:0] rv);
    logic a, b, c;
    frame(32, 1'b1, pa, ra, 16'h0000, 16, rv, a, b, c);
  endtask

  task automatic do_write(input int pre, input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] d);
    logic [15:0] rv;
    logic a, b, c;
    frame(pre, 1'b0, pa, ra, d, 16, rv, a, b, c);
    repeat (4) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [15:0] rv;
    rst_int_n = 1'b0;
    mif.phy_mdc = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if ({mif.phy_mdio_oe, mif.phy_mdio_o, wr_valid, phy_reset_req} !== 4'b0000) begin
      failed++;
      $display("FAIL reset_ctl: oe,o,wv,rr=%b expected 0000",
               {mif.phy_mdio_oe, mif.phy_mdio_o, wr_valid, phy_reset_req});
    end
    tests_run++;
    if ({wr_addr, wr_data} !== 21'd0) begin
      failed++;
      $display("FAIL reset_wr: addr=%h data=%h expected 0/0", wr_addr, wr_data);
    end
    rst_int_n = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    do_read(5'd1, 5'd0, rv);
    tests_run++;
    if (rv !== model_read(5'd0)) begin
      failed++;
      $display("FAIL reset_bmcr: got %h expected %h", rv, model_read(5'd0));
    end
    do_read(5'd1, 5'd4, rv);
    tests_run++;
    if (rv !== 16'h0000) begin
      failed++;
      $display("FAIL reset_reg4: got %h expected 0000", rv);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] rv;
    int w0;
    bit rr;
    w0 = wr_cnt;
    do_write(32, 5'd1, 5'd4, 16'h01E1);
    model_write(5'd4, 16'h01E1, rr);
    tests_run++;
    if ((wr_cnt - w0) !== 1 || wr_addr !== 5'd4 || wr_data !== 16'h01E1) begin
      failed++;
      $display("FAIL write_reg4: pulses=%0d addr=%h data=%h expected 1/04/01e1",
               wr_cnt - w0, wr_addr, wr_data);
    end
    do_read(5'd1, 5'd4, rv);
    tests_run++;
    if (rv !== 16'h01E1) begin
      failed++;
      $display("FAIL read_reg4: got %h expected 01e1", rv);
    end
  endtask

  task automatic test_phyid();
    logic [15:0] rv;
    logic t1, t2, tv;
    for (int r = 2; r <= 3; r++) begin
      frame(32, 1'b1, 5'd1, 5'(r), 16'h0000, 16, rv, t1, t2, tv);
      tests_run++;
      if (rv !== model_read(5'(r))) begin
        failed++;
        $display("FAIL phyid_reg%0d: got %h expected %h", r, rv, model_read(5'(r)));
      end
      tests_run++;
      if ({t1, t2, tv, mif.phy_mdio_oe} !== 4'b0100) begin
        failed++;
        $display("FAIL phyid_ta%0d: ta1_oe,ta2_oe,ta2_val,end_oe=%b expected 0100",
                 r, {t1, t2, tv, mif.phy_mdio_oe});
      end
    end
  endtask

  task automatic test_bmsr();
    logic [15:0] rv;
    int w0;
    link_up = 1'b1;
    do_read(5'd1, 5'd1, rv);
    tests_run++;
    if (rv !== 16'h794D) begin
      failed++;
      $display("FAIL bmsr_link1: got %h expected 794d", rv);
    end
    link_up = 1'b0;
    do_read(5'd1, 5'd1, rv);
    tests_run++;
    if (rv !== 16'h7949) begin
      failed++;
      $display("FAIL bmsr_link0: got %h expected 7949", rv);
    end
    w0 = wr_cnt;
    do_write(32, 5'd1, 5'd1, 16'hFFFF);
    do_read(5'd1, 5'd1, rv);
    tests_run++;
    if (rv !== 16'h7949 || (wr_cnt - w0) !== 1) begin
      failed++;
      $display("FAIL bmsr_ro: got %h pulses=%0d expected 7949/1", rv, wr_cnt - w0);
    end
  endtask

  task automatic test_soft_reset();
    logic [15:0] rv;
    int r0;
    bit rr;
    do_write(32, 5'd1, 5'd4, 16'h0000);
    model_write(5'd4, 16'h0000, rr);
    do_write(32, 5'd1, 5'd7, 16'hBEEF);
    model_write(5'd7, 16'hBEEF, rr);
    r0 = rr_cnt;
    do_write(32, 5'd1, 5'd0, 16'h9140);
    model_write(5'd0, 16'h9140, rr);
    tests_run++;
    if ((rr_cnt - r0) !== 1) begin
      failed++;
      $display("FAIL soft_reset_pulse: got %0d expected 1", rr_cnt - r0);
    end
    do_read(5'd1, 5'd0, rv);
    tests_run++;
    if (rv !== 16'h1140) begin
      failed++;
      $display("FAIL soft_reset_bmcr: got %h expected 1140", rv);
    end
    do_read(5'd1, 5'd7, rv);
    tests_run++;
    if (rv !== model_read(5'd7)) begin
      failed++;
      $display("FAIL soft_reset_reg7: got %h expected %h", rv, model_read(5'd7));
    end
  endtask

  task automatic test_mismatch_and_preamble();
    logic [15:0] rv;
    int w0, o0;
    bit rr;
    w0 = wr_cnt;
    o0 = oe_cnt;
    do_write(32, 5'd2, 5'd5, 16'h1234);
    do_read(5'd2, 5'd0, rv);
    tests_run++;
    if ((wr_cnt - w0) !== 0 || (oe_cnt - o0) !== 0 || rv !== 16'hFFFF) begin
      failed++;
      $display("FAIL phyad_mismatch: pulses=%0d oe_cycles=%0d rd=%h expected 0/0/ffff",
               wr_cnt - w0, oe_cnt - o0, rv);
    end
    w0 = wr_cnt;
    do_write(31, 5'd1, 5'd5, 16'hA5C3);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    model_write(5'd5, 16'hA5C3, rr);
    tests_run++;
    if ((wr_cnt - w0) !== 1) begin
      failed++;
      $display("FAIL short_preamble: pulses=%0d expected 1", wr_cnt - w0);
    end
`else
    rr = 1'b0;
    tests_run++;
    if ((wr_cnt - w0) !== 0) begin
      failed++;
      $display("FAIL short_preamble: pulses=%0d expected 0", wr_cnt - w0);
    end
`endif
    do_read(5'd1, 5'd5, rv);
    tests_run++;
    if (rv !== model_read(5'd5)) begin
      failed++;
      $display("FAIL short_preamble_rd: got %h expected %h (rst %0b)", rv, model_read(5'd5), rr);
    end
  endtask

  task automatic test_random();
    logic [15:0] rv, d;
    logic [4:0] ra, pa;
    bit rd, rr;
    int w0, r0;
    for (int n = 0; n < 16; n++) begin
      ra = 5'($urandom_range(0, 31));
      d  = 16'($urandom);
      if (ra == 5'd0) d[15] = ($urandom_range(0, 3) == 0);
      rd = $urandom_range(0, 1) == 1;
      pa = ($urandom_range(0, 4) == 0) ? 5'd9 : 5'd1;
      link_up = $urandom_range(0, 1) == 1;
      if (rd) begin
        do_read(pa, ra, rv);
        tests_run++;
        if (rv !== ((pa == 5'd1) ? model_read(ra) : 16'hFFFF)) begin
          failed++;
          $display("FAIL rand_read: pa=%0d ra=%0d got %h expected %h", pa, ra, rv,
                   (pa == 5'd1) ? model_read(ra) : 16'hFFFF);
        end
      end else begin
        w0 = wr_cnt;
        r0 = rr_cnt;
        do_write(32, pa, ra, d);
        rr = 1'b0;
        if (pa == 5'd1) model_write(ra, d, rr);
        tests_run++;
        if ((wr_cnt - w0) !== ((pa == 5'd1) ? 1 : 0) || (rr_cnt - r0) !== int'(rr) ||
            (pa == 5'd1 && (wr_addr !== ra || wr_data !== d))) begin
          failed++;
          $display("FAIL rand_write: pa=%0d ra=%0d d=%h pulses=%0d rreq=%0d addr=%h data=%h",
                   pa, ra, d, wr_cnt - w0, rr_cnt - r0, wr_addr, wr_data);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] rv;
    logic t1, t2, tv;
    bit rr;
    do_write(32, 5'd1, 5'd0, 16'h0100);
    model_write(5'd0, 16'h0100, rr);
    frame(32, 1'b1, 5'd1, 5'd0, 16'h0000, 7, rv, t1, t2, tv);
    tests_run++;
    if (mif.phy_mdio_oe !== 1'b1) begin
      failed++;
      $display("FAIL midframe_oe_before: got %b expected 1", mif.phy_mdio_oe);
    end
    @(negedge clk);
    rst_int_n = 1'b0;
    #1;
    tests_run++;
    if (mif.phy_mdio_oe !== 1'b0) begin
      failed++;
      $display("FAIL midframe_oe_release: got %b expected 0", mif.phy_mdio_oe);
    end
    repeat (4) @(negedge clk);
    rst_int_n = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
    do_read(5'd1, 5'd0, rv);
    tests_run++;
    if (rv !== model_read(5'd0)) begin
      failed++;
      $display("FAIL midframe_after: got %h expected %h", rv, model_read(5'd0));
    end
  endtask

  initial begin
    mif.phy_mdc = 1'b0;
    test_reset();
    test_write_read();
    test_phyid();
    test_bmsr();
    test_soft_reset();
    test_mismatch_and_preamble();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
